// File: rtl/fft_gain_pkg.sv
// Shared types and constants for the FFT front-end gain scheduler.
package fft_gain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_DECIDE
   } gain_state_e;

   localparam int unsigned BIN_W = 3;

   // Lower bit index of each 8-bit magnitude group; G3 runs up to PW-2.
   localparam int unsigned G0_LO = 4;
   localparam int unsigned G1_LO = 12;
   localparam int unsigned G2_LO = 20;
   localparam int unsigned G3_LO = 28;

   localparam int unsigned BIN_MAX = 4;

   function automatic bit tgt_bin_ok(input int tgt);
      return (tgt >= 0) && (tgt <= int'(BIN_MAX));
   endfunction

endpackage

// File: rtl/fft_pwr_bin.sv
// Combinational magnitude binning of a signed power word into 8-bit groups.
module fft_pwr_bin
   import fft_gain_pkg::*;
#(
   parameter int unsigned PW = 35
) (
   input  logic signed [PW-1:0]    pwr,
   output logic        [BIN_W-1:0] bin
);

   logic unused_low;
   assign unused_low = ^pwr[G0_LO-1:0];

   always_comb begin
      bin = '0;
      // Highest nonzero group wins, so later tests override earlier ones.
      if (!pwr[PW-1]) begin
         if (|pwr[G1_LO-1:G0_LO]) bin = BIN_W'(1);
         if (|pwr[G2_LO-1:G1_LO]) bin = BIN_W'(2);
         if (|pwr[G3_LO-1:G2_LO]) bin = BIN_W'(3);
         if (|pwr[PW-2:G3_LO])    bin = BIN_W'(4);
      end
   end

endmodule

// File: rtl/fft_gain_ctrl.sv
// Closed-loop gain scheduler: windowed peak-bin tracking, gain stepping, decoder freeze.
// Optional FFT_GAIN_CTRL_STATS_EN adds saturating up_cnt/dn_cnt step counters.
module fft_gain_ctrl
   import fft_gain_pkg::*;
#(
   parameter int unsigned PW      = 35,
   parameter int unsigned WIN     = 64,
   parameter int unsigned SETTLE  = 8,
   parameter int unsigned GMAX    = 7,
   parameter int unsigned TGT_BIN = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic signed [PW-1:0]          pwr,
   input  logic                          pwr_vld,
   output logic [$clog2(GMAX+1)-1:0]     gain,
   output logic                          gain_upd,
   output logic                          freeze,
   output logic [2:0]                    peak_bin,
   output logic                          busy,
`ifdef FFT_GAIN_CTRL_STATS_EN
   output logic [15:0]                   up_cnt,
   output logic [15:0]                   dn_cnt,
`endif
   output logic                          locked
);

   localparam int unsigned GW  = $clog2(GMAX + 1);
   localparam int unsigned SCW = $clog2(SETTLE + 1);
   localparam int unsigned NCW = $clog2(WIN + 1);
   localparam logic [BIN_W-1:0] TGT    = BIN_W'(TGT_BIN);
   localparam logic [GW-1:0]    GMAX_C = GW'(GMAX);

   if (!tgt_bin_ok(int'(TGT_BIN))) begin : g_bad_tgt_bin
      $error("fft_gain_ctrl: TGT_BIN must be within 0..4");
   end

   gain_state_e       state_q, state_d;
   logic [GW-1:0]     gain_q, gain_d;
   logic              gain_upd_q, gain_upd_d;
   logic              freeze_q, freeze_d;
   logic [BIN_W-1:0]  peak_bin_q, peak_bin_d;
   logic              busy_q, busy_d;
   logic              locked_q, locked_d;
   logic [SCW-1:0]    set_cnt_q, set_cnt_d;
   logic [NCW-1:0]    smp_cnt_q, smp_cnt_d;
   logic [BIN_W-1:0]  peak_q, peak_d;
   logic [BIN_W-1:0]  bin;
   logic              go_up, go_dn;

   fft_pwr_bin #(.PW(PW)) u_bin (
      .pwr (pwr),
      .bin (bin)
   );

   always_comb begin
      state_d    = state_q;
      gain_d     = gain_q;
      gain_upd_d = 1'b0;
      peak_bin_d = peak_bin_q;
      locked_d   = locked_q;
      set_cnt_d  = set_cnt_q;
      smp_cnt_d  = smp_cnt_q;
      peak_d     = peak_q;
      go_up      = 1'b0;
      go_dn      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d   = ST_SETTLE;
               set_cnt_d = '0;
            end
         end
         ST_SETTLE: begin
            if (set_cnt_q == SCW'(SETTLE - 1)) begin
               state_d   = ST_MEASURE;
               smp_cnt_d = '0;
               peak_d    = '0;
            end else begin
               set_cnt_d = set_cnt_q + SCW'(1);
            end
         end
         ST_MEASURE: begin
            if (pwr_vld) begin
               smp_cnt_d = smp_cnt_q + NCW'(1);
               if (bin > peak_q) peak_d = bin;
               if (smp_cnt_q == NCW'(WIN - 1)) state_d = ST_DECIDE;
            end
         end
         ST_DECIDE: begin
            peak_bin_d = peak_q;
            if (peak_q > TGT && gain_q != '0)          go_dn = 1'b1;
            else if (peak_q < TGT && gain_q != GMAX_C) go_up = 1'b1;
            if (go_up || go_dn) begin
               gain_d     = go_up ? gain_q + GW'(1) : gain_q - GW'(1);
               gain_upd_d = 1'b1;
               locked_d   = 1'b0;
               state_d    = ST_SETTLE;
               set_cnt_d  = '0;
            end else begin
               locked_d  = 1'b1;
               state_d   = ST_MEASURE;
               smp_cnt_d = '0;
               peak_d    = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Disable overrides every state, including a DECIDE in progress.
      if (!en) begin
         state_d    = ST_IDLE;
         gain_d     = gain_q;
         gain_upd_d = 1'b0;
         peak_bin_d = peak_bin_q;
         locked_d   = 1'b0;
         set_cnt_d  = '0;
         smp_cnt_d  = '0;
         peak_d     = '0;
         go_up      = 1'b0;
         go_dn      = 1'b0;
      end

      freeze_d = (state_d == ST_SETTLE) || (state_d == ST_DECIDE);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gain_q     <= GW'(GMAX / 2);
         gain_upd_q <= 1'b0;
         freeze_q   <= 1'b0;
         peak_bin_q <= '0;
         busy_q     <= 1'b0;
         locked_q   <= 1'b0;
         set_cnt_q  <= '0;
         smp_cnt_q  <= '0;
         peak_q     <= '0;
      end else begin
         state_q    <= state_d;
         gain_q     <= gain_d;
         gain_upd_q <= gain_upd_d;
         freeze_q   <= freeze_d;
         peak_bin_q <= peak_bin_d;
         busy_q     <= busy_d;
         locked_q   <= locked_d;
         set_cnt_q  <= set_cnt_d;
         smp_cnt_q  <= smp_cnt_d;
         peak_q     <= peak_d;
      end
   end

`ifdef FFT_GAIN_CTRL_STATS_EN
   logic [15:0] up_cnt_q, up_cnt_d;
   logic [15:0] dn_cnt_q, dn_cnt_d;

   always_comb begin
      up_cnt_d = up_cnt_q;
      dn_cnt_d = dn_cnt_q;
      if (go_up && up_cnt_q != '1) up_cnt_d = up_cnt_q + 16'd1;
      if (go_dn && dn_cnt_q != '1) dn_cnt_d = dn_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         up_cnt_q <= '0;
         dn_cnt_q <= '0;
      end else begin
         up_cnt_q <= up_cnt_d;
         dn_cnt_q <= dn_cnt_d;
      end
   end

   assign up_cnt = up_cnt_q;
   assign dn_cnt = dn_cnt_q;
`endif

   assign gain     = gain_q;
   assign gain_upd = gain_upd_q;
   assign freeze   = freeze_q;
   assign peak_bin = peak_bin_q;
   assign busy     = busy_q;
   assign locked   = locked_q;

endmodule

// File: tb/tb_fft_gain_ctrl.sv
// Directed self-checking bench for fft_gain_ctrl (WIN=4, SETTLE=2, GMAX=7, TGT_BIN=2).
module tb_fft_gain_ctrl;

   localparam int unsigned PW = 35;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic signed [PW-1:0] pwr;
   logic                 pwr_vld;
   logic [2:0]           gain;
   logic                 gain_upd;
   logic                 freeze;
   logic [2:0]           peak_bin;
   logic                 busy;
   logic                 locked;
`ifdef FFT_GAIN_CTRL_STATS_EN
   logic [15:0]          up_cnt;
   logic [15:0]          dn_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   fft_gain_ctrl #(
      .PW      (PW),
      .WIN     (4),
      .SETTLE  (2),
      .GMAX    (7),
      .TGT_BIN (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pwr      (pwr),
      .pwr_vld  (pwr_vld),
      .gain     (gain),
      .gain_upd (gain_upd),
      .freeze   (freeze),
      .peak_bin (peak_bin),
      .busy     (busy),
`ifdef FFT_GAIN_CTRL_STATS_EN
      .up_cnt   (up_cnt),
      .dn_cnt   (dn_cnt),
`endif
      .locked   (locked)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Four valid samples from MEASURE; afterwards the DUT sits in DECIDE.
   task automatic send_window(input logic [PW-1:0] first, input logic [PW-1:0] rest);
      for (int i = 0; i < 4; i++) begin
         pwr     = (i == 0) ? first : rest;
         pwr_vld = 1'b1;
         tick();
      end
      pwr_vld = 1'b0;
      pwr     = '0;
   endtask

   initial begin
      logic [PW-1:0] s_bin1, s_bin2, s_bin4, s_neg;
      s_bin1 = 35'h0_0000_0010;
      s_bin2 = 35'h0_0000_1000;
      s_bin4 = 35'h1_0000_0000;
      s_neg  = '1;

      rst = 1'b1; en = 1'b0; pwr = '0; pwr_vld = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_gain",     gain,     3);
      chk("rst_gain_upd", gain_upd, 0);
      chk("rst_freeze",   freeze,   0);
      chk("rst_peak_bin", peak_bin, 0);
      chk("rst_busy",     busy,     0);
      chk("rst_locked",   locked,   0);

      en = 1'b1;
      tick();
      chk("start_freeze1", freeze, 1);
      chk("start_busy",    busy,   1);
      tick();
      chk("start_freeze2", freeze, 1);
      tick();
      chk("measure_freeze", freeze, 0);
      tick(); tick(); tick();
      chk("wait_busy",   busy,   1);
      chk("wait_freeze", freeze, 0);

      // On-target window: no change, locked, straight back to MEASURE
      send_window(s_bin2, s_bin2);
      chk("tgt_decide_freeze", freeze, 1);
      tick();
      chk("tgt_peak_bin", peak_bin, 2);
      chk("tgt_gain",     gain,     3);
      chk("tgt_locked",   locked,   1);
      chk("tgt_upd",      gain_upd, 0);
      chk("tgt_freeze",   freeze,   0);

      // Overload in first sample only: gain down one, 3 cycles of freeze
      send_window(s_bin4, s_bin1);
      chk("dn_freeze0", freeze, 1);
      tick();
      chk("dn_gain",     gain,     2);
      chk("dn_upd",      gain_upd, 1);
      chk("dn_freeze1",  freeze,   1);
      chk("dn_locked",   locked,   0);
      chk("dn_peak_bin", peak_bin, 4);
      tick();
      chk("dn_upd_pulse", gain_upd, 0);
      chk("dn_freeze2",   freeze,   1);
      tick();
      chk("dn_freeze3", freeze, 0);

      // Low-level windows climb the gain to the rail
      for (int g = 3; g <= 7; g++) begin
         send_window(s_bin1, s_bin1);
         tick();
         chk("up_gain", gain,     g);
         chk("up_upd",  gain_upd, 1);
         tick(); tick();
      end
      send_window(s_bin1, s_bin1);
      tick();
      chk("rail_gain",   gain,     7);
      chk("rail_locked", locked,   1);
      chk("rail_upd",    gain_upd, 0);
      chk("rail_freeze", freeze,   0);
      chk("rail_peak",   peak_bin, 1);
`ifdef FFT_GAIN_CTRL_STATS_EN
      chk("stats_up", up_cnt, 5);
      chk("stats_dn", dn_cnt, 1);
`endif

      // Step down, then a negative window reads as bin 0 and steps up
      send_window(s_bin4, s_bin4);
      tick();
      chk("hi_gain", gain, 6);
      tick(); tick();
      send_window(s_neg, s_neg);
      tick();
      chk("neg_gain",     gain,     7);
      chk("neg_peak_bin", peak_bin, 0);
      chk("neg_upd",      gain_upd, 1);
      tick(); tick();

      // Partial window discarded on disable
      pwr = s_bin4; pwr_vld = 1'b1;
      tick(); tick();
      pwr_vld = 1'b0; en = 1'b0;
      tick();
      chk("dis_busy",   busy,   0);
      chk("dis_freeze", freeze, 0);
      chk("dis_locked", locked, 0);
      chk("dis_gain",   gain,   7);
      tick();
      en = 1'b1;
      tick();
      chk("re_freeze1", freeze, 1);
      tick();
      chk("re_freeze2", freeze, 1);
      tick();
      chk("re_measure", freeze, 0);
      pwr = s_bin2; pwr_vld = 1'b1;
      tick(); tick();
      chk("re_half_freeze", freeze, 0);
      tick(); tick();
      pwr_vld = 1'b0;
      chk("re_decide_freeze", freeze, 1);
      tick();
      chk("re_peak_bin", peak_bin, 2);
      chk("re_gain",     gain,     7);
      chk("re_locked",   locked,   1);

      // Reset wins over a simultaneous enable
      rst = 1'b1;
      tick();
      chk("rsten_busy",   busy,     0);
      chk("rsten_gain",   gain,     3);
      chk("rsten_peak",   peak_bin, 0);
      chk("rsten_locked", locked,   0);
`ifdef FFT_GAIN_CTRL_STATS_EN
      chk("rsten_up", up_cnt, 0);
`endif
      rst = 1'b0;
      tick();
      chk("rsten_start_freeze", freeze, 1);
      chk("rsten_start_busy",   busy,   1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
